// File: rtl/fetch_aligner_if.sv
// fetch_aligner_if: bundles the IF-side and ICACHE-side signals of the fetch aligner.
//
//   IF side:
//     pc           IF program counter (pc[0] ignored)
//     ready        inst/compressed valid for pc this cycle
//     compressed   instruction at pc is 16-bit
//     inst         aligned instruction (NOP 32'h00000013 when not ready)
//   ICACHE side:
//     ICACHE_stall  cache busy; read completes when ren=1 and stall=0
//     ICACHE_ren    read request
//     ICACHE_wen    write enable (tied 0)
//     ICACHE_addr   word address of the request
//     ICACHE_rdata  byte-reversed read data
//     ICACHE_wdata  write data (tied 0)
//
// The master modport is the aligner; the slave modport is its environment (IF stage + cache).
interface fetch_aligner_if;
    logic [31:0] pc;
    logic        ready;
    logic        compressed;
    logic [31:0] inst;

    logic        ICACHE_stall;
    logic        ICACHE_ren;
    logic        ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] ICACHE_wdata;

    modport master (
        input  pc,
        input  ICACHE_stall,
        input  ICACHE_rdata,
        output ready,
        output compressed,
        output inst,
        output ICACHE_ren,
        output ICACHE_wen,
        output ICACHE_addr,
        output ICACHE_wdata
    );

    modport slave (
        output pc,
        output ICACHE_stall,
        output ICACHE_rdata,
        input  ready,
        input  compressed,
        input  inst,
        input  ICACHE_ren,
        input  ICACHE_wen,
        input  ICACHE_addr,
        input  ICACHE_wdata
    );
endinterface

// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction-fetch front end between ICACHE and the IF stage.
//
// Fetches 32-bit words from the cache, restores their byte order and extracts the 16-bit
// (RVC) or 32-bit instruction at any halfword-aligned pc, including 32-bit instructions that
// straddle a word boundary. A last-word buffer (LAST) plus a one-halfword spill register
// (SPILL, the high half of the previously buffered word) let straight-line code use one
// cache access per word.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   fetch_aligner_if.master (pc/ready/compressed/inst and the ICACHE_* signals)
module fetch_aligner (
    input logic            clk,
    input logic            rst,
    fetch_aligner_if.master bus
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    localparam logic [31:0] NopInst = 32'h00000013;

    logic [0:0]  state_q, state_d;
    logic [29:0] fetch_addr_q, fetch_addr_d;

    logic        last_v_q;
    logic [29:0] last_tag_q;
    logic [31:0] last_data_q;

    logic        spill_v_q;
    logic [29:0] spill_tag_q;
    logic [15:0] spill_hi_q;

    logic [31:0] word;
    logic [29:0] w_tag, w1_tag;
    logic        last_hit_w, last_hit_w1, spill_ok;
    logic        h0_v, h1_v;
    logic [15:0] h0, h1;
    logic        is_rvc;
    logic        miss;
    logic [29:0] miss_addr;
    logic        req;
    logic [29:0] req_addr;
    logic        capture;

    logic unused_pc0;
    assign unused_pc0 = bus.pc[0];

    // The cache returns the byte at address 4k in rdata[31:24].
    assign word = {bus.ICACHE_rdata[7:0],   bus.ICACHE_rdata[15:8],
                   bus.ICACHE_rdata[23:16], bus.ICACHE_rdata[31:24]};

    assign w_tag  = bus.pc[31:2];
    assign w1_tag = w_tag + 30'd1;  // wraps modulo 2^30

    assign last_hit_w  = last_v_q && (last_tag_q == w_tag);
    assign last_hit_w1 = last_v_q && (last_tag_q == w1_tag);

    // SPILL is only usable while it still directly precedes the word held in LAST.
    assign spill_ok = spill_v_q && last_v_q && (last_tag_q == spill_tag_q + 30'd1);

    // Halfword selection.
    always_comb begin
        h0_v = 1'b0;
        h0   = 16'h0000;
        h1_v = 1'b0;
        h1   = 16'h0000;
        if (!bus.pc[1]) begin
            h0_v = last_hit_w;
            h0   = last_data_q[15:0];
            h1_v = last_hit_w;
            h1   = last_data_q[31:16];
        end else begin
            // After a straddle refill LAST holds W1, so the first half comes from SPILL.
            if (spill_ok && (spill_tag_q == w_tag)) begin
                h0_v = 1'b1;
                h0   = spill_hi_q;
            end else if (last_hit_w) begin
                h0_v = 1'b1;
                h0   = last_data_q[31:16];
            end
            h1_v = last_hit_w1;
            h1   = last_data_q[15:0];
        end
    end

    assign is_rvc = h0_v && (h0[1:0] != 2'b11);

    // Missing word while IDLE: first half takes priority over the second half.
    always_comb begin
        miss      = 1'b0;
        miss_addr = w_tag;
        if (!h0_v) begin
            miss      = 1'b1;
            miss_addr = w_tag;
        end else if (!is_rvc && bus.pc[1] && !h1_v) begin
            miss      = 1'b1;
            miss_addr = w1_tag;
        end
    end

    // Request / FSM next state.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req          = 1'b0;
        req_addr     = 30'h0;
        capture      = 1'b0;
        case (state_q)
            StIdle: begin
                if (miss) begin
                    req      = 1'b1;
                    req_addr = miss_addr;
                    if (!bus.ICACHE_stall) begin
                        capture = 1'b1;
                    end else begin
                        state_d      = StWait;
                        fetch_addr_d = miss_addr;
                    end
                end
            end
            StWait: begin
                // pc is ignored here: a redirect lets the outstanding read finish first.
                req      = 1'b1;
                req_addr = fetch_addr_q;
                if (!bus.ICACHE_stall) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Reset drops the request immediately, without waiting for an edge.
        if (rst) begin
            req      = 1'b0;
            req_addr = 30'h0;
            capture  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            fetch_addr_q <= 30'h0;
            last_v_q     <= 1'b0;
            last_tag_q   <= 30'h0;
            last_data_q  <= 32'h0;
            spill_v_q    <= 1'b0;
            spill_tag_q  <= 30'h0;
            spill_hi_q   <= 16'h0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            if (capture) begin
                spill_v_q   <= last_v_q;
                spill_tag_q <= last_tag_q;
                spill_hi_q  <= last_data_q[31:16];
                last_v_q    <= 1'b1;
                last_tag_q  <= req_addr;
                last_data_q <= word;
            end
        end
    end

    always_comb begin
        bus.ready      = !rst && (state_q == StIdle) && h0_v && (is_rvc || h1_v);
        bus.compressed = !rst && is_rvc;
        if (!bus.ready) begin
            bus.inst = NopInst;
        end else if (is_rvc) begin
            bus.inst = {16'h0000, h0};
        end else begin
            bus.inst = {h1, h0};
        end
    end

    assign bus.ICACHE_ren   = req;
    assign bus.ICACHE_addr  = req_addr;
    assign bus.ICACHE_wen   = 1'b0;
    assign bus.ICACHE_wdata = 32'h0;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge. The cache is a small table of words in
// natural byte order, presented byte-reversed on ICACHE_rdata.
module tb_fetch_aligner;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fetch_aligner_if bus ();

    fetch_aligner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] w0, w1, w2, w10, w20, wtop;
    logic [31:0] cache_word;

    always_comb begin
        case (bus.ICACHE_addr)
            30'h0000_0000: cache_word = w0;
            30'h0000_0001: cache_word = w1;
            30'h0000_0002: cache_word = w2;
            30'h0000_0010: cache_word = w10;
            30'h0000_0020: cache_word = w20;
            30'h3FFF_FFFF: cache_word = wtop;
            default:       cache_word = 32'h0;
        endcase
    end

    assign bus.ICACHE_rdata = {cache_word[7:0], cache_word[15:8],
                               cache_word[23:16], cache_word[31:24]};

    int checks = 0;
    int errors = 0;

    task automatic do_reset();
        rst = 1'b1;
        bus.pc = 32'h0;
        bus.ICACHE_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        w0 = 32'h00450513;
        bus.pc = 32'h0;
        bus.ICACHE_stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.ICACHE_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", bus.ICACHE_ren); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        checks++; if (bus.inst !== 32'h00000013) begin errors++; $display("FAIL reset_inst got %h want 00000013", bus.inst); end
        checks++; if (bus.compressed !== 1'b0) begin errors++; $display("FAIL reset_compressed got %b want 0", bus.compressed); end
        checks++; if (bus.ICACHE_addr !== 30'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.ICACHE_addr); end
        checks++; if (bus.ICACHE_wen !== 1'b0 || bus.ICACHE_wdata !== 32'h0) begin errors++; $display("FAIL reset_write got wen=%b wdata=%h want 0/0", bus.ICACHE_wen, bus.ICACHE_wdata); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h0) begin errors++; $display("FAIL first_req got ren=%b addr=%h want 1/0", bus.ICACHE_ren, bus.ICACHE_addr); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL first_req_ready got %b want 0", bus.ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00450513 || bus.compressed !== 1'b0) begin errors++; $display("FAIL first_inst got rdy=%b inst=%h c=%b want 1/00450513/0", bus.ready, bus.inst, bus.compressed); end
        checks++; if (bus.ICACHE_ren !== 1'b0) begin errors++; $display("FAIL first_hit_ren got %b want 0", bus.ICACHE_ren); end
    endtask

    task automatic test_compressed();
        w0 = 32'h05054501;
        do_reset();
        bus.pc = 32'h0;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h0) begin errors++; $display("FAIL rvc_req got ren=%b addr=%h want 1/0", bus.ICACHE_ren, bus.ICACHE_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00004501 || bus.compressed !== 1'b1) begin errors++; $display("FAIL rvc_lo got rdy=%b inst=%h c=%b want 1/00004501/1", bus.ready, bus.inst, bus.compressed); end
        next_cycle();
        bus.pc = 32'h2;
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00000505 || bus.compressed !== 1'b1) begin errors++; $display("FAIL rvc_hi got rdy=%b inst=%h c=%b want 1/00000505/1", bus.ready, bus.inst, bus.compressed); end
        checks++; if (bus.ICACHE_ren !== 1'b0) begin errors++; $display("FAIL rvc_hi_ren got %b want 0", bus.ICACHE_ren); end
    endtask

    // Continues from test_compressed: word 0 is still buffered.
    task automatic test_straddle();
        w1 = 32'h05130001;
        w2 = 32'h05050045;
        next_cycle();
        bus.pc = 32'h6;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h1 || bus.ready !== 1'b0) begin errors++; $display("FAIL straddle_req1 got ren=%b addr=%h rdy=%b want 1/1/0", bus.ICACHE_ren, bus.ICACHE_addr, bus.ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h2 || bus.ready !== 1'b0) begin errors++; $display("FAIL straddle_req2 got ren=%b addr=%h rdy=%b want 1/2/0", bus.ICACHE_ren, bus.ICACHE_addr, bus.ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00450513 || bus.compressed !== 1'b0) begin errors++; $display("FAIL straddle_inst got rdy=%b inst=%h c=%b want 1/00450513/0", bus.ready, bus.inst, bus.compressed); end
        checks++; if (bus.ICACHE_ren !== 1'b0) begin errors++; $display("FAIL straddle_hit_ren got %b want 0", bus.ICACHE_ren); end
        next_cycle();
        bus.pc = 32'hA;
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00000505 || bus.ICACHE_ren !== 1'b0) begin errors++; $display("FAIL seq_after_straddle got rdy=%b inst=%h ren=%b want 1/00000505/0", bus.ready, bus.inst, bus.ICACHE_ren); end
    endtask

    task automatic test_stall();
        w10 = 32'h00450513;
        w20 = 32'h00A00093;
        do_reset();
        bus.pc = 32'h40;
        bus.ICACHE_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h10 || bus.ready !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d] got ren=%b addr=%h rdy=%b want 1/10/0", i, bus.ICACHE_ren, bus.ICACHE_addr, bus.ready); end
            next_cycle();
        end
        bus.ICACHE_stall = 1'b0;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h10 || bus.ready !== 1'b0) begin errors++; $display("FAIL stall_done got ren=%b addr=%h rdy=%b want 1/10/0", bus.ICACHE_ren, bus.ICACHE_addr, bus.ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00450513 || bus.ICACHE_ren !== 1'b0) begin errors++; $display("FAIL stall_ready got rdy=%b inst=%h ren=%b want 1/00450513/0", bus.ready, bus.inst, bus.ICACHE_ren); end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.pc = 32'h40;
        bus.ICACHE_stall = 1'b1;
        @(negedge clk);
        checks++; if (bus.ICACHE_addr !== 30'h10) begin errors++; $display("FAIL redir_req got addr=%h want 10", bus.ICACHE_addr); end
        next_cycle();
        bus.pc = 32'h80;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h10 || bus.ready !== 1'b0) begin errors++; $display("FAIL redir_hold got ren=%b addr=%h rdy=%b want 1/10/0", bus.ICACHE_ren, bus.ICACHE_addr, bus.ready); end
        next_cycle();
        bus.ICACHE_stall = 1'b0;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h10) begin errors++; $display("FAIL redir_complete got ren=%b addr=%h want 1/10", bus.ICACHE_ren, bus.ICACHE_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h20 || bus.ready !== 1'b0) begin errors++; $display("FAIL redir_newreq got ren=%b addr=%h rdy=%b want 1/20/0", bus.ICACHE_ren, bus.ICACHE_addr, bus.ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00A00093) begin errors++; $display("FAIL redir_inst got rdy=%b inst=%h want 1/00a00093", bus.ready, bus.inst); end
    endtask

    task automatic test_wrap();
        wtop = 32'h05130001;
        w0   = 32'h05050045;
        do_reset();
        bus.pc = 32'hFFFFFFFE;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h3FFFFFFF) begin errors++; $display("FAIL wrap_req1 got ren=%b addr=%h want 1/3fffffff", bus.ICACHE_ren, bus.ICACHE_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h0 || bus.ready !== 1'b0) begin errors++; $display("FAIL wrap_req2 got ren=%b addr=%h rdy=%b want 1/0/0", bus.ICACHE_ren, bus.ICACHE_addr, bus.ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00450513 || bus.ICACHE_ren !== 1'b0) begin errors++; $display("FAIL wrap_inst got rdy=%b inst=%h ren=%b want 1/00450513/0", bus.ready, bus.inst, bus.ICACHE_ren); end
    endtask

    task automatic test_reset_wait();
        w10 = 32'h00450513;
        do_reset();
        bus.pc = 32'h40;
        bus.ICACHE_stall = 1'b1;
        next_cycle();
        #2;
        checks++; if (bus.ICACHE_ren !== 1'b1) begin errors++; $display("FAIL rstwait_pre got ren=%b want 1", bus.ICACHE_ren); end
        rst = 1'b1;
        #1;
        checks++; if (bus.ICACHE_ren !== 1'b0 || bus.ready !== 1'b0 || bus.ICACHE_addr !== 30'h0) begin errors++; $display("FAIL rstwait_drop got ren=%b rdy=%b addr=%h want 0/0/0", bus.ICACHE_ren, bus.ready, bus.ICACHE_addr); end
        next_cycle();
        rst = 1'b0;
        bus.ICACHE_stall = 1'b0;
        @(negedge clk);
        checks++; if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'h10) begin errors++; $display("FAIL rstwait_refetch got ren=%b addr=%h want 1/10", bus.ICACHE_ren, bus.ICACHE_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.inst !== 32'h00450513) begin errors++; $display("FAIL rstwait_inst got rdy=%b inst=%h want 1/00450513", bus.ready, bus.inst); end
    endtask

    initial begin
        w0   = 32'h0;
        w1   = 32'h0;
        w2   = 32'h0;
        w10  = 32'h0;
        w20  = 32'h0;
        wtop = 32'h0;
        bus.pc = 32'h0;
        bus.ICACHE_stall = 1'b0;
        test_reset();
        test_compressed();
        test_straddle();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
